hsv2rgb_arbiter: RTL and testbench



---
 rtl/hsv_arb_pkg.sv | 30 +++
 rtl/hsv2rgb.sv | 89 ++++++++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/hsv2rgb_arbiter.sv | 137 +++++++++++++
 tb/tb_hsv2rgb_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hsv_arb_pkg.sv
// Shared constants and pixel/tag types for the hsv2rgb arbiter slice.
package hsv_arb_pkg;

  localparam int unsigned HSV2RGB_LAT = 10;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W    = 3;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
  } hsv_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  typedef enum logic [0:0] {
    StRun,
    StDrain
  } arb_state_e;

endpackage

// File: rtl/hsv2rgb.sv
// Fixed-latency HSV to RGB converter: four arithmetic stages plus a delay line up to Lat.
// Not reset; the caller's tag pipe decides which results are meaningful.
module hsv2rgb
  import hsv_arb_pkg::*;
#(
  parameter int unsigned Lat = HSV2RGB_LAT
) (
  input  logic        clk_i,
  input  logic [23:0] hsv_i,
  output logic [23:0] rgb_o
);

  hsv_t pix;
  assign pix = hsv_i;

  logic [2:0] s1_reg_d, s1_reg_q, s2_reg_d, s2_reg_q, s3_reg_d, s3_reg_q;
  logic [7:0] s1_rem_d, s1_rem_q, s1_s_d, s1_s_q, s1_v_d, s1_v_q;
  logic [7:0] s2_v_d, s2_v_q, s2_p_d, s2_p_q, s2_sr_d, s2_sr_q, s2_srn_d, s2_srn_q;
  logic [7:0] s3_v_d, s3_v_q, s3_p_d, s3_p_q, s3_q_d, s3_q_q, s3_t_d, s3_t_q;
  rgb_t       s4_d, s4_q;

  always_comb begin
    // Hue splits into six 43-wide sectors; rem is the position within a sector scaled to 0..252.
    s1_reg_d = 3'(pix.h / 8'd43);
    s1_rem_d = (pix.h - 8'(s1_reg_d) * 8'd43) * 8'd6;
    s1_s_d   = pix.s;
    s1_v_d   = pix.v;

    s2_reg_d = s1_reg_q;
    s2_v_d   = s1_v_q;
    s2_p_d   = 8'((16'(s1_v_q) * 16'(8'd255 - s1_s_q)) >> 8);
    s2_sr_d  = 8'((16'(s1_s_q) * 16'(s1_rem_q)) >> 8);
    s2_srn_d = 8'((16'(s1_s_q) * 16'(8'd255 - s1_rem_q)) >> 8);

    s3_reg_d = s2_reg_q;
    s3_v_d   = s2_v_q;
    s3_p_d   = s2_p_q;
    s3_q_d   = 8'((16'(s2_v_q) * 16'(8'd255 - s2_sr_q)) >> 8);
    s3_t_d   = 8'((16'(s2_v_q) * 16'(8'd255 - s2_srn_q)) >> 8);

    case (s3_reg_q)
      3'd0:    s4_d = {s3_v_q, s3_t_q, s3_p_q};
      3'd1:    s4_d = {s3_q_q, s3_v_q, s3_p_q};
      3'd2:    s4_d = {s3_p_q, s3_v_q, s3_t_q};
      3'd3:    s4_d = {s3_p_q, s3_q_q, s3_v_q};
      3'd4:    s4_d = {s3_t_q, s3_p_q, s3_v_q};
      default: s4_d = {s3_v_q, s3_p_q, s3_q_q};
    endcase
  end

  always_ff @(posedge clk_i) begin
    s1_reg_q <= s1_reg_d;
    s1_rem_q <= s1_rem_d;
    s1_s_q   <= s1_s_d;
    s1_v_q   <= s1_v_d;
    s2_reg_q <= s2_reg_d;
    s2_v_q   <= s2_v_d;
    s2_p_q   <= s2_p_d;
    s2_sr_q  <= s2_sr_d;
    s2_srn_q <= s2_srn_d;
    s3_reg_q <= s3_reg_d;
    s3_v_q   <= s3_v_d;
    s3_p_q   <= s3_p_d;
    s3_q_q   <= s3_q_d;
    s3_t_q   <= s3_t_d;
    s4_q     <= s4_d;
  end

  if (Lat > 4) begin : g_dly
    rgb_t dly_q [Lat-4];
    rgb_t dly_d [Lat-4];

    always_comb begin
      dly_d[0] = s4_q;
      for (int unsigned i = 1; i < Lat - 4; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      dly_q <= dly_d;
    end

    assign rgb_o = dly_q[Lat-5];
  end else begin : g_nodly
    assign rgb_o = s4_q;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant over NReq requesters with its pointer register.
// Search starts one past the last winner; the pointer only moves on a grant.
module rr_arbiter #(
  parameter int unsigned NReq = 4,
  localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [NReq-1:0] valid_i,
  output logic [NReq-1:0] grant_o,
  output logic            gnt_o,
  output logic [IdxW-1:0] gnt_id_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;
  logic            found;
  int unsigned     idx;

  always_comb begin
    found    = 1'b0;
    gnt_id_o = '0;
    idx      = 0;
    cand     = '0;
    for (int unsigned k = 1; k <= NReq; k++) begin
      idx  = (32'(ptr_q) + k) % NReq;
      cand = IdxW'(idx);
      if (!found && valid_i[cand]) begin
        found    = 1'b1;
        gnt_id_o = cand;
      end
    end
  end

  assign gnt_o = en_i & found;

  always_comb begin
    grant_o = '0;
    if (gnt_o) begin
      grant_o[gnt_id_o] = 1'b1;
    end
    ptr_d = gnt_o ? gnt_id_o : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= IdxW'(NReq - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hsv2rgb_arbiter.sv
// Round-robin front end sharing one hsv2rgb pipeline among NREQ requesters, with a tag pipe.
// Define HSV2RGB_ARB_STATS_EN to add per-requester result counters (stat_cnt, stat_clr).
module hsv2rgb_arbiter
  import hsv_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned PIPE_LAT = HSV2RGB_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [24*NREQ-1:0] req_hsv,
  input  logic               drain,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [23:0]        rsp_rgb,
  output logic               idle
`ifdef HSV2RGB_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [16*NREQ-1:0] stat_cnt
`endif
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic            arb_en;
  logic            transfer;
  logic [IdxW-1:0] gnt_id;
  logic [23:0]     pipe_hsv;
  tag_t            tag_q [PIPE_LAT];
  tag_t            tag_d [PIPE_LAT];
  logic            inflight;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain)  state_d = StDrain;
      StDrain: if (!drain) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // A raised drain blocks grants in the same cycle, before the state register follows.
  assign arb_en = (state_q == StRun) & ~drain & ~rst;

  rr_arbiter #(
    .NReq (NREQ)
  ) u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (arb_en),
    .valid_i  (req_valid),
    .grant_o  (req_ready),
    .gnt_o    (transfer),
    .gnt_id_o (gnt_id)
  );

  always_comb begin
    pipe_hsv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) pipe_hsv = req_hsv[24*i +: 24];
    end
  end

  hsv2rgb #(
    .Lat (PIPE_LAT)
  ) u_cvt (
    .clk_i (clk),
    .hsv_i (pipe_hsv),
    .rgb_o (rsp_rgb)
  );

  always_comb begin
    tag_d[0] = {transfer, TAG_ID_W'(gnt_id)};
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = tag_q[PIPE_LAT-1].vld && (tag_q[PIPE_LAT-1].id == TAG_ID_W'(i));
    end
    inflight = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight | tag_q[i].vld;
    end
  end

  assign idle = ~inflight & ~transfer;

`ifdef HSV2RGB_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (rsp_valid[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
      stat_cnt[16*i +: 16] = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_hsv2rgb_arbiter.sv
// Randomized self-checking bench for hsv2rgb_arbiter against a cycle-level behavioural model.
module tb_hsv2rgb_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 10;
  localparam int unsigned R    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [24*NREQ-1:0] req_hsv;
  logic               drain;
  logic [NREQ-1:0]    rsp_valid;
  logic [23:0]        rsp_rgb;
  logic               idle;
`ifdef HSV2RGB_ARB_STATS_EN
  logic               stat_clr;
  logic [16*NREQ-1:0] stat_cnt;
`endif

  hsv2rgb_arbiter #(
    .NREQ     (NREQ),
    .PIPE_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_hsv   (req_hsv),
    .drain     (drain),
    .rsp_valid (rsp_valid),
    .rsp_rgb   (rsp_rgb),
    .idle      (idle)
`ifdef HSV2RGB_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        pend [NREQ];
  logic [23:0] phsv [NREQ];
  logic [NREQ-1:0] act_mask;
  int unsigned prob;
  logic        drv_rst, drv_drain, drv_clr;
  int          m_ptr;
  logic        m_drain;
  logic        started;
  logic        ring_v   [R];
  int          ring_id  [R];
  logic [23:0] ring_rgb [R];
  logic [15:0] m_cnt    [NREQ];
  int          watch_cyc;
  logic [23:0] watch_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Integer HSV->RGB with 8-bit hue split into six 43-step sectors.
  function automatic logic [23:0] ref_rgb(input logic [23:0] hsv);
    int h, s, v, sec, rem, p, q, t, r, g, b;
    h   = int'(hsv[23:16]);
    s   = int'(hsv[15:8]);
    v   = int'(hsv[7:0]);
    sec = h / 43;
    rem = (h - sec * 43) * 6;
    p   = (v * (255 - s)) / 256;
    q   = (v * (255 - (s * rem) / 256)) / 256;
    t   = (v * (255 - (s * (255 - rem)) / 256)) / 256;
    case (sec)
      0:       begin r = v; g = t; b = p; end
      1:       begin r = q; g = v; b = p; end
      2:       begin r = p; g = v; b = t; end
      3:       begin r = p; g = q; b = v; end
      4:       begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic tick();
    int              g, idx, ri, wi;
    logic [NREQ-1:0] exp_ready, exp_rsp;
    logic            exp_idle;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && act_mask[i] && ($urandom_range(99) < prob)) begin
        pend[i] = 1'b1;
        phsv[i] = 24'($urandom());
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend[i];
      req_hsv[24*i +: 24]   = phsv[i];
    end
    rst   = drv_rst;
    drain = drv_drain;
`ifdef HSV2RGB_ARB_STATS_EN
    stat_clr = drv_clr;
`endif
    #4;
    g = -1;
    if (!drv_rst && !m_drain && !drv_drain) begin
      for (int k = 1; k <= int'(NREQ); k++) begin
        idx = (m_ptr + k) % int'(NREQ);
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));

    ri = cyc % int'(R);
    if (started && !drv_rst) begin
      exp_rsp = '0;
      if (ring_v[ri]) exp_rsp[ring_id[ri]] = 1'b1;
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (ring_v[ri]) check("rsp_rgb", 32'(rsp_rgb), 32'(ring_rgb[ri]));
      exp_idle = (g < 0);
      for (int c = 0; c < int'(LAT); c++) begin
        if (ring_v[(cyc + c) % int'(R)]) exp_idle = 1'b0;
      end
      check("idle", 32'(idle), 32'(exp_idle));
      if (cyc == watch_cyc) check("rgb_literal", 32'(rsp_rgb), 32'(watch_rgb));
`ifdef HSV2RGB_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) begin
        check("stat_cnt", 32'(stat_cnt[16*i +: 16]), 32'(m_cnt[i]));
      end
`endif
    end

    if (drv_rst) begin
      m_ptr   = int'(NREQ) - 1;
      m_drain = 1'b0;
      started = 1'b1;
      for (int c = 1; c <= int'(LAT); c++) ring_v[(cyc + c) % int'(R)] = 1'b0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
    end else begin
      if (drv_clr) begin
        for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
      end else if (ring_v[ri] && m_cnt[ring_id[ri]] != 16'hFFFF) begin
        m_cnt[ring_id[ri]] = m_cnt[ring_id[ri]] + 16'd1;
      end
      if (g >= 0) begin
        wi           = (cyc + int'(LAT)) % int'(R);
        ring_v[wi]   = 1'b1;
        ring_id[wi]  = g;
        ring_rgb[wi] = ref_rgb(phsv[g]);
        m_ptr        = g;
        pend[g]      = 1'b0;
      end
      m_drain = drv_drain;
    end
    ring_v[ri] = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i]  = 1'b0;
      phsv[i]  = '0;
      m_cnt[i] = '0;
    end
    for (int i = 0; i < int'(R); i++) begin
      ring_v[i]   = 1'b0;
      ring_id[i]  = 0;
      ring_rgb[i] = '0;
    end
    act_mask  = '0;
    prob      = 0;
    drv_rst   = 1'b1;
    drv_drain = 1'b0;
    drv_clr   = 1'b0;
    m_ptr     = int'(NREQ) - 1;
    m_drain   = 1'b0;
    started   = 1'b0;
    watch_cyc = -1;
    watch_rgb = '0;
    req_valid = '0;
    req_hsv   = '0;
    rst       = 1'b1;
    drain     = 1'b0;
`ifdef HSV2RGB_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif

    repeat (3) tick();
    drv_rst = 1'b0;
    repeat (2) tick();

    // Lone requester 0, pure red.
    pend[0] = 1'b1; phsv[0] = 24'h00FFFF;
    watch_cyc = cyc + int'(LAT); watch_rgb = 24'hFF0000;
    repeat (12) tick();
    // Requester 2, grey with truncation.
    pend[2] = 1'b1; phsv[2] = 24'h0000C8;
    watch_cyc = cyc + int'(LAT); watch_rgb = 24'hC8C7C7;
    repeat (12) tick();

    // All requesters continuously valid from reset.
    drv_rst = 1'b1; repeat (2) tick(); drv_rst = 1'b0;
    act_mask = '1; prob = 100;
    repeat (24) tick();

    // Drain with pixels in flight and all requesters still valid.
    act_mask = '0; repeat (14) tick();
    act_mask = '1; repeat (6) tick();
    drv_drain = 1'b1; repeat (16) tick();
    drv_drain = 1'b0; repeat (12) tick();

    // Reset mid-flight after a burst.
    repeat (8) tick();
    act_mask = '0; repeat (5) tick();
    drv_rst = 1'b1; tick(); drv_rst = 1'b0;
    repeat (12) tick();
    act_mask = '1; repeat (6) tick();
    act_mask = '0; repeat (14) tick();

`ifdef HSV2RGB_ARB_STATS_EN
    drv_clr = 1'b1; tick(); drv_clr = 1'b0;
    act_mask = 4'b0010; prob = 100;
    repeat (300) tick();
    act_mask = '0; repeat (12) tick();
    check("stat1_300", 32'(stat_cnt[31:16]), 32'd300);
    pend[1] = 1'b1; phsv[1] = 24'($urandom());
    repeat (10) tick();
    drv_clr = 1'b1; tick(); drv_clr = 1'b0;
    check("stat_clr_wins", 32'(stat_cnt[31:16]), 32'd0);
`endif

    for (int n = 0; n < 2000; n++) begin
      if (n % 50 == 0) begin
        act_mask = NREQ'($urandom());
        prob     = $urandom_range(100, 10);
      end
      drv_drain = ($urandom_range(99) < 4);
      drv_rst   = ($urandom_range(999) < 3);
      drv_clr   = ($urandom_range(999) < 5);
      tick();
    end
    drv_drain = 1'b0; drv_rst = 1'b0; drv_clr = 1'b0; act_mask = '0;
    repeat (16) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
